// File: rtl/full_add_bit.sv
// One-bit full-adder cell; purely combinational leaf of the ripple chain.
module full_add_bit (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);

  logic p;

  assign p  = x ^ y;
  assign s  = p ^ ci;
  assign co = (x & y) | (ci & p);

endmodule

// File: rtl/full_add.sv
// Ripple-carry adder of width+1 bits with carry in/out and a registered result.
module full_add #(
  parameter int unsigned width = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [width:0] a,
  input  logic [width:0] b,
  input  logic           c_in,
  output logic [width:0] sum,
  output logic           c_out
);

  localparam int unsigned N = width + 1;

  logic [N:0]     carry;
  logic [width:0] sum_n;
  logic           c_out_n;

  assign carry[0] = c_in;
  assign c_out_n  = carry[N];

  // Cell i consumes carry[i] and produces carry[i+1]
  for (genvar i = 0; i < int'(N); i++) begin : g_cell
    full_add_bit u_bit (
      .x  (a[i]),
      .y  (b[i]),
      .ci (carry[i]),
      .s  (sum_n[i]),
      .co (carry[i+1])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum   <= '0;
      c_out <= 1'b0;
    end else begin
      sum   <= sum_n;
      c_out <= c_out_n;
    end
  end

endmodule

// File: tb/tb_full_add.sv
// Bench for full_add at width 0, 2 and 15 against an arithmetic reference.
module tb_full_add;

  logic        clk;
  logic        rst;
  logic [2:0]  a2, b2, sum2;
  logic        c2, co2;
  logic [0:0]  a0, b0, sum0;
  logic        c0, co0;
  logic [15:0] a15, b15, sum15;
  logic        c15, co15;

  int n_chk;
  int n_fail;
  int e2, e0, e15;

  full_add #(.width(2)) dut2 (
    .clk(clk), .rst(rst), .a(a2), .b(b2), .c_in(c2), .sum(sum2), .c_out(co2)
  );
  full_add #(.width(0)) dut0 (
    .clk(clk), .rst(rst), .a(a0), .b(b0), .c_in(c0), .sum(sum0), .c_out(co0)
  );
  full_add #(.width(15)) dut15 (
    .clk(clk), .rst(rst), .a(a15), .b(b15), .c_in(c15), .sum(sum15), .c_out(co15)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference: the full integer sum a+b+c_in seen at each edge, zero under reset
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      e2 <= 0; e0 <= 0; e15 <= 0;
    end else begin
      e2  <= int'(a2) + int'(b2) + int'(c2);
      e0  <= int'(a0) + int'(b0) + int'(c0);
      e15 <= int'(a15) + int'(b15) + int'(c15);
    end
  end

  // Compare every cycle: {c_out,sum} must equal the full integer result
  always @(negedge clk) begin
    check("w2_cycle",  int'({co2, sum2}),   e2);
    check("w0_cycle",  int'({co0, sum0}),   e0);
    check("w15_cycle", int'({co15, sum15}), e15);
  end

  task automatic rand_others();
    a0 = 1'($urandom); b0 = 1'($urandom); c0 = 1'($urandom);
    a15 = 16'($urandom); b15 = 16'($urandom); c15 = 1'($urandom);
  endtask

  task automatic apply(input logic [2:0] a, input logic [2:0] b, input logic c);
    @(posedge clk);
    #2;
    a2 = a; b2 = b; c2 = c;
    rand_others();
  endtask

  task automatic expect_lit(input string name, input int s, input int co);
    @(posedge clk);
    #1;
    check({name, "_sum"}, int'(sum2), s);
    check({name, "_cout"}, int'(co2), co);
  endtask

  logic [2:0] va [3];
  logic [2:0] vb [3];
  logic       vc [3];
  int         vs [3];
  int         vo [3];

  initial begin
    n_chk = 0; n_fail = 0;
    rst = 1'b1;
    a2 = 3'd5; b2 = 3'd6; c2 = 1'b1;
    rand_others();

    // Reset held across several edges while operands are live
    repeat (3) begin
      @(posedge clk);
      #1;
      check("rst_hold_sum", int'(sum2), 0);
      check("rst_hold_cout", int'(co2), 0);
    end
    @(negedge clk);
    rst = 1'b0;
    expect_lit("rst_release", 4, 1);

    apply(3'd3, 3'd2, 1'b1); expect_lit("basic", 6, 0);
    apply(3'd7, 3'd7, 1'b1); expect_lit("max", 7, 1);
    apply(3'd7, 3'd0, 1'b1); expect_lit("wrap", 0, 1);
    apply(3'd0, 3'd0, 1'b0); expect_lit("zero", 0, 0);

    // Back-to-back operands, each result one edge later
    va[0] = 3'd1; vb[0] = 3'd1; vc[0] = 1'b0; vs[0] = 2; vo[0] = 0;
    va[1] = 3'd4; vb[1] = 3'd2; vc[1] = 1'b1; vs[1] = 7; vo[1] = 0;
    va[2] = 3'd6; vb[2] = 3'd3; vc[2] = 1'b0; vs[2] = 1; vo[2] = 1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      if (i > 0) begin
        check("b2b_sum", int'(sum2), vs[i-1]);
        check("b2b_cout", int'(co2), vo[i-1]);
      end
      a2 = va[i]; b2 = vb[i]; c2 = vc[i];
      rand_others();
    end
    @(posedge clk);
    #1;
    check("b2b_sum", int'(sum2), vs[2]);
    check("b2b_cout", int'(co2), vo[2]);

    // Asynchronous reset pulse between edges clears without a clock edge
    #1;
    rst = 1'b1;
    #1;
    check("async_rst_sum", int'(sum2), 0);
    check("async_rst_cout", int'(co2), 0);
    check("async_rst_w15", int'({co15, sum15}), 0);
    a2 = 3'd2; b2 = 3'd2; c2 = 1'b0;
    #1;
    rst = 1'b0;
    expect_lit("post_rst", 4, 0);

    // Random operands on every cycle, checked by the per-cycle compare
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk);
      #2;
      a2 = 3'($urandom); b2 = 3'($urandom); c2 = 1'($urandom);
      rand_others();
    end
    @(posedge clk);
    @(negedge clk);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
